// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- memory BIST controller.
// Holds the FSM state encoding, element indices and default geometry.
package mbist_pkg;

  localparam int DEF_DATA_W = 56;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    CMP,
    DONE
  } state_t;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  function automatic logic [2:0] elem_of(input state_t s);
    case (s)
      M1:      return ELEM_M1;
      M2:      return ELEM_M2;
      M3:      return ELEM_M3;
      M4:      return ELEM_M4;
      M5:      return ELEM_M5;
      default: return ELEM_M0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; load has priority over counting.
// last flags the final address of the current direction (all-ones up, zero down).
module mbist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (en) begin
      addr <= down ? (addr - ONE) : (addr + ONE);
    end
  end

  assign last = down ? (addr == '0) : (addr == {ADDR_W{1'b1}});

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: one memory op per cycle, 10N op cycles, read checked one cycle later.
// Build with MBIST_STOP_ON_FAIL_EN defined to end the run at the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              MBIST_start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              MBIST_done,
  output logic              MBIST_fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t state, next_state;
  // phase 0 is the read slot and phase 1 the write slot of an r,w element
  logic phase, next_phase;

  logic              ag_load, ag_en, ag_down, ag_last;
  logic [ADDR_W-1:0] ag_load_val, addr;

  logic rd, wr, wbg, rbg;

  logic              cmp_vld, cmp_bg;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_elem;
  logic              mismatch, start_ok;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ag_load),
    .load_val (ag_load_val),
    .en       (ag_en),
    .down     (ag_down),
    .addr     (addr),
    .last     (ag_last)
  );

  assign start_ok = MBIST_start && ((state == IDLE) || (state == DONE));
  assign mismatch = cmp_vld && (mem_rdata != {DATA_W{cmp_bg}});

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      phase <= 1'b0;
    end else begin
      state <= next_state;
      phase <= next_phase;
    end
  end

  always_comb begin
    next_state  = state;
    next_phase  = 1'b0;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_en       = 1'b0;
    ag_down     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    wbg         = 1'b0;
    rbg         = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (MBIST_start) begin
          next_state = M0;
          ag_load    = 1'b1;
        end
      end
      M0: begin
        wr    = 1'b1;
        ag_en = 1'b1;
        if (ag_last) begin
          next_state = M1;
          ag_load    = 1'b1;
        end
      end
      M1, M2, M3, M4: begin
        ag_down = (state == M3) || (state == M4);
        rbg     = (state == M2) || (state == M4);
        wbg     = ~rbg;
        if (!phase) begin
          rd         = 1'b1;
          next_phase = 1'b1;
        end else begin
          wr    = 1'b1;
          ag_en = 1'b1;
          if (ag_last) begin
            ag_load = 1'b1;
            case (state)
              M1: begin
                next_state  = M2;
                ag_load_val = '0;
              end
              M2: begin
                next_state  = M3;
                ag_load_val = ADDR_LAST;
              end
              M3: begin
                next_state  = M4;
                ag_load_val = ADDR_LAST;
              end
              default: begin
                next_state  = M5;
                ag_load_val = '0;
              end
            endcase
          end
        end
      end
      M5: begin
        rd    = 1'b1;
        ag_en = 1'b1;
        if (ag_last) begin
          next_state = CMP;
        end
      end
      CMP: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
`ifdef MBIST_STOP_ON_FAIL_EN
    // strobes of the compare cycle still issue; everything after it is cut
    if (mismatch) begin
      next_state = DONE;
      next_phase = 1'b0;
    end
`endif
  end

  assign mem_re     = rd;
  assign mem_we     = wr;
  assign mem_addr   = (rd || wr) ? addr : '0;
  assign mem_wdata  = wr ? {DATA_W{wbg}} : '0;
  assign MBIST_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmp_vld  <= 1'b0;
      cmp_bg   <= 1'b0;
      cmp_addr <= '0;
      cmp_elem <= ELEM_M0;
    end else begin
      cmp_vld  <= rd && (next_state != DONE);
      cmp_bg   <= rbg;
      cmp_addr <= addr;
      cmp_elem <= elem_of(state);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      MBIST_fail <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= ELEM_M0;
    end else if (start_ok) begin
      MBIST_fail <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= ELEM_M0;
    end else if (mismatch) begin
      MBIST_fail <= 1'b1;
      if (!MBIST_fail) begin
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
    end
  end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 56, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width; N = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port MBIST_start  input  1  run request, sampled each edge.
REQ-006 SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after a read.
REQ-007 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-008 SHALL have port mem_wdata  output  DATA_W  write data.
REQ-009 SHALL have port mem_we  output  1  write strobe.
REQ-010 SHALL have port mem_re  output  1  read strobe.
REQ-011 SHALL have port MBIST_done  output  1  level; run finished.
REQ-012 SHALL have port MBIST_fail  output  1  sticky; at least one mismatch this run.
REQ-013 SHALL have port fail_addr  output  ADDR_W  address of first mismatch.
REQ-014 SHALL have port fail_elem  output  3  March element index (0-5) of first mismatch.

Function
REQ-015 SHALL implement March C-: M0 any-order(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 any-order(r0). M0 and M5 run ascending.
REQ-016 Background "0" SHALL be all DATA_W bits 0 and "1" all bits 1.
REQ-017 FSM states SHALL be IDLE, M0, M1, M2, M3, M4, M5, CMP, DONE.
REQ-018 Exactly one memory operation SHALL issue per cycle, for 10N operation cycles total.
REQ-019 In each r,w element, the read at address a SHALL issue in cycle k and the write at address a in cycle k+1.
REQ-020 Each read SHALL be compared against its expected background at the edge after issue, one-cycle synchronous read.
REQ-021 CMP SHALL last one cycle to compare the final M5 read, then go to DONE.
REQ-022 A MBIST_start sampled in IDLE or DONE SHALL clear MBIST_done, MBIST_fail, fail_addr and fail_elem, then enter M0.
REQ-023 MBIST_start SHALL be ignored in every other state.
REQ-024 Timing: with start sampled at edge 0, operations occupy cycles 1..10N and MBIST_done rises at edge 10N+1.
REQ-025 MBIST_done SHALL stay high in DONE until the next start or reset.
REQ-026 Element transitions SHALL occur on the address counter reaching its last address (N-1 going up, 0 going down), with no idle cycle between elements.
REQ-027 mem_we and mem_re SHALL never be high in the same cycle, and both SHALL be 0 in IDLE, CMP and DONE.
REQ-028 On the first mismatch, fail_addr and fail_elem SHALL be captured; later mismatches SHALL only keep MBIST_fail high.

Reset
REQ-029 While rstn=0 at an edge: state SHALL be IDLE and all outputs 0.
REQ-030 Reset mid-run SHALL abort the test within the same edge; no further memory strobes until a new start.

Configuration
REQ-031 With MBIST_STOP_ON_FAIL_EN defined, the first mismatch SHALL move the FSM to DONE at the compare edge, with MBIST_done high the following cycle.
REQ-032 Without MBIST_STOP_ON_FAIL_EN, the run SHALL always complete all six elements.

Structure
REQ-033 Package mbist_pkg SHALL hold the state enum, the element-index constants (M0=0..M5=5) and the default DATA_W and ADDR_W.
REQ-034 Sub-module mbist_addr_gen SHALL be a loadable up/down ADDR_W counter with a last-address flag, instantiated once.

Verification
REQ-035 Fault-free 256-word model, start pulse: MBIST_done rises at edge 2561, with MBIST_fail=0.
REQ-036 Bit 0 stuck-at-1 at address 0x05: MBIST_fail=1, fail_addr=0x05, fail_elem=1, done at edge 2561 (macro off).
REQ-037 Same fault with MBIST_STOP_ON_FAIL_EN defined: done high the cycle after the M1 read of 0x05 is compared; no further strobes.
REQ-038 rstn low at cycle 1000 of a run: all outputs 0 the next cycle; a fresh start then gives a clean 2561-cycle run.
REQ-039 Start pulse at cycle 500 mid-run: ignored, completion still at edge 2561.
REQ-040 Bench SHALL check every cycle that mem_we and mem_re are never both high, and that the address order is ascending in M1/M2 and descending in M3/M4.
